btn_debounce: RTL
=================

// Module: btn_debounce
// PURPOSE
//   Debounces the Basys3 push buttons using the slow sample clock clk_deb produced by debounce_div.
//   Sits directly downstream of debounce_div; everything runs on the single system clock clk.
//   clk_deb is used only as a sample-enable source (edge-detected), never as a clock.
//   Outputs a clean level per button plus one-cycle press/release pulses for the VGA control logic.
// PARAMETERS
//   N_BTN       5   number of buttons debounced (bit 0 = btnC, 1 = btnU, 2 = btnL, 3 = btnR, 4 = btnD)
//   STABLE_CNT  4   consecutive differing samples required to accept a change (legal range 1..15)
// PORTS
//   clk          in   1      system clock, 100 MHz
//   rst_n        in   1      reset, asynchronous, active-low
//   clk_deb      in   1      slow sample clock from debounce_div (same domain as clk)
//   btn_in       in   N_BTN  raw asynchronous button pins, 1 = pressed
//   btn_level    out  N_BTN  debounced level, 1 = pressed
//   btn_press    out  N_BTN  1-cycle pulse on accepted 0->1 change
//   btn_release  out  N_BTN  1-cycle pulse on accepted 1->0 change
// BEHAVIOUR
//   Reset (rst_n=0, async): btn_level, btn_press, btn_release = 0.
//     Synchronizer flops = 0, all counters = 0, clk_deb_d = 1.
//   Synchronizer: each btn_in bit passes through 2 flops (s1 -> s2).
//     Only s2 (btn_sync) is used downstream.
//   Sample tick: clk_deb_d is clk_deb registered once.
//     tick = clk_deb & ~clk_deb_d (combinational, high for exactly 1 clk cycle per clk_deb rising edge).
//     clk_deb_d resets to 1, so clk_deb already high at reset release gives no tick until its next rise.
//   Per-button counter cnt[i], width 4 bits, saturating is never needed (cleared on acceptance).
//   On a tick cycle, for each i independently:
//     btn_sync[i] == btn_level[i]: cnt[i] <= 0 (bounce or no change; partial count discarded).
//     btn_sync[i] != btn_level[i] and cnt[i] <  STABLE_CNT-1: cnt[i] <= cnt[i]+1.
//     btn_sync[i] != btn_level[i] and cnt[i] == STABLE_CNT-1: accept the change.
//       btn_level[i] <= btn_sync[i]; cnt[i] <= 0.
//       Pulse btn_press[i] if the new level is 1, else btn_release[i].
//   On non-tick cycles: cnt and btn_level hold; btn_press and btn_release = 0.
//   Pulses are registered, exactly 1 clk wide, and visible in the cycle after the accepting tick.
//     btn_press[i] and btn_release[i] are never high together.
//   Latency: a clean edge on btn_in is accepted on the STABLE_CNT-th tick at which btn_sync differs.
//     btn_sync lags btn_in by 2 clk.
//     With debounce_div (tick period 65536 clk), acceptance takes about STABLE_CNT x 655 us.
//   Simultaneous changes on several buttons are handled in parallel with no interaction.
//   rst_n asserted mid-count: counters and levels clear immediately, with no pulse emitted.
//   No other state: no FSM beyond the per-bit counter/level pair.
// TESTING (bench drives clk_deb directly, tick every 16 clk, STABLE_CNT=4)
//   1. Clean press: btn_in[0] 0->1 and held.
//      -> btn_level[0]=1 on the 4th tick after btn_sync rises; btn_press[0] high exactly 1 cycle; others stay 0.
//   2. Bounce: btn_in[1] high for 3 ticks, low for 1 tick, then high for 4 ticks.
//      -> no output during the first 3; btn_level[1] rises on the 4th tick of the final run.
//   3. Release: from btn_level[2]=1, drive btn_in[2]=0 for 4 ticks.
//      -> btn_release[2] 1-cycle pulse; btn_level[2]=0; btn_press stays 0.
//   4. Simultaneous: btn_in=5'b11111 from 0.
//      -> all btn_press bits pulse in the same cycle; btn_level=5'b11111.
//   5. Reset mid-count: drop rst_n after 2 ticks of a press, then release reset with btn_in held.
//      -> btn_level=0 with no pulse; a full 4 fresh ticks are required before press.
//   6. Reset edge case: release rst_n with clk_deb=1 held high.
//      -> no tick and no count until clk_deb falls and rises again.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop synchronizer, clk_deb rising-edge sample tick, and a
// per-button consecutive-difference counter that updates a clean level and emits edge pulses.
module btn_debounce #(
  parameter int unsigned N_BTN      = 5,
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_deb,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam logic [3:0] CntLast = 4'(STABLE_CNT - 1);

  logic [N_BTN-1:0]      sync1_q, sync2_q;
  logic                  clk_deb_q;
  logic                  tick;
  logic [N_BTN-1:0][3:0] cnt_q, cnt_d;
  logic [N_BTN-1:0]      level_q, level_d;
  logic [N_BTN-1:0]      press_q, press_d;
  logic [N_BTN-1:0]      release_q, release_d;

  // clk_deb is only a sample enable; one tick per rising edge.
  assign tick = clk_deb & ~clk_deb_q;

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] < CntLast) begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end else begin
          cnt_d[i]     = '0;
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end
      end
    end
  end

  // clk_deb_q resets high so a clk_deb already high at reset release is not a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      clk_deb_q <= 1'b1;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      clk_deb_q <= clk_deb;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
